// File: rtl/icache_dm_if.sv
// Fetch-side and backing-memory-side bus of icache_dm.
// master: front end plus backing memory; slave: the cache itself.
interface icache_dm_if #(
   parameter int FETCH_WORDS = 2
);
   logic                      req_valid;
   logic                      req_ready;
   logic [31:0]               req_addr;
   logic                      resp_valid;
   logic [32*FETCH_WORDS-1:0] resp_data;
   logic [FETCH_WORDS-1:0]    resp_mask;
   logic                      flush;
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic [31:0]               mem_req_addr;
   logic                      mem_resp_valid;
   logic [31:0]               mem_resp_data;

   modport master (
      output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  req_ready, resp_valid, resp_data, resp_mask, mem_req_valid, mem_req_addr
   );

   modport slave (
      input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
      output req_ready, resp_valid, resp_data, resp_mask, mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, FETCH_WORDS lanes per response, word-wide line refill.
// Optional ICACHE_PERF_CNT_EN adds hit_count / miss_count ports.
module icache_dm #(
   parameter int NUM_LINES   = 64,
   parameter int LINE_WORDS  = 4,
   parameter int FETCH_WORDS = 2
) (
   input  logic        clk,
   input  logic        rst,
   icache_dm_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
   localparam logic [31:0]      NOP       = 32'h0000_0013;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, RESPOND} state_t;

   logic [31:0]      words [NUM_LINES][LINE_WORDS];
   logic [TAG_W-1:0] tags  [NUM_LINES];
   logic [NUM_LINES-1:0] valid;

   state_t           state;
   logic [OFF_W-1:0] beat;
   logic [TAG_W-1:0] miss_tag;
   logic [IDX_W-1:0] miss_idx;
   logic [OFF_W-1:0] miss_off;
   logic             flush_pending;

   logic [OFF_W-1:0] req_off;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic             accept;
   logic             hit;
   logic [IDX_W-1:0] rd_idx;
   logic [32*LINE_WORDS-1:0] rd_line;
   logic             unused_addr_bits;
   logic             last_fill;

   function automatic logic [32*FETCH_WORDS-1:0] lane_data(
      input logic [32*LINE_WORDS-1:0] line,
      input logic [OFF_W-1:0]         off
   );
      lane_data = '0;
      for (int i = 0; i < FETCH_WORDS; i++) begin
         if (int'(off) + i < LINE_WORDS)
            lane_data[32*i +: 32] = line[32*(int'(off) + i) +: 32];
         else
            lane_data[32*i +: 32] = NOP;
      end
   endfunction

   function automatic logic [FETCH_WORDS-1:0] lane_mask(input logic [OFF_W-1:0] off);
      lane_mask = '0;
      for (int i = 0; i < FETCH_WORDS; i++)
         lane_mask[i] = (int'(off) + i < LINE_WORDS);
   endfunction

   assign req_off          = bus.req_addr[2 +: OFF_W];
   assign req_idx          = bus.req_addr[2 + OFF_W +: IDX_W];
   assign req_tag          = bus.req_addr[31 -: TAG_W];
   assign unused_addr_bits = ^bus.req_addr[1:0];

   assign bus.req_ready = (state == IDLE) && !rst;
   assign accept        = bus.req_valid && bus.req_ready;
   // A flush in the accept cycle forces a miss even if the line looks valid.
   assign hit           = valid[req_idx] && (tags[req_idx] == req_tag) && !bus.flush;
   assign last_fill     = (state == MISS_WAIT) && bus.mem_resp_valid && (beat == LAST_BEAT);

   always_comb begin
      rd_idx  = (state == IDLE) ? req_idx : miss_idx;
      rd_line = '0;
      for (int i = 0; i < LINE_WORDS; i++)
         rd_line[32*i +: 32] = words[rd_idx][i];
   end

   // Line storage: written one beat at a time during refill, never reset.
   always_ff @(posedge clk) begin
      if (state == MISS_WAIT && bus.mem_resp_valid) begin
         words[miss_idx][beat] <= bus.mem_resp_data;
         if (beat == LAST_BEAT)
            tags[miss_idx] <= miss_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         valid             <= '0;
         beat              <= '0;
         miss_tag          <= '0;
         miss_idx          <= '0;
         miss_off          <= '0;
         flush_pending     <= 1'b0;
         bus.resp_valid    <= 1'b0;
         bus.resp_data     <= {FETCH_WORDS{NOP}};
         bus.resp_mask     <= '0;
         bus.mem_req_valid <= 1'b0;
         bus.mem_req_addr  <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (hit) begin
                     bus.resp_valid <= 1'b1;
                     bus.resp_data  <= lane_data(rd_line, req_off);
                     bus.resp_mask  <= lane_mask(req_off);
                  end else begin
                     miss_tag          <= req_tag;
                     miss_idx          <= req_idx;
                     miss_off          <= req_off;
                     beat              <= '0;
                     bus.mem_req_valid <= 1'b1;
                     bus.mem_req_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                     state             <= MISS_REQ;
                  end
               end
            end
            MISS_REQ: begin
               if (bus.mem_req_ready) begin
                  bus.mem_req_valid <= 1'b0;
                  state             <= MISS_WAIT;
               end
            end
            MISS_WAIT: begin
               if (bus.mem_resp_valid) begin
                  if (beat == LAST_BEAT) begin
                     state <= RESPOND;
                  end else begin
                     beat              <= beat + OFF_W'(1);
                     bus.mem_req_valid <= 1'b1;
                     bus.mem_req_addr  <= {miss_tag, miss_idx, beat + OFF_W'(1), 2'b00};
                     state             <= MISS_REQ;
                  end
               end
            end
            RESPOND: begin
               // First cycle emits the pulse, second cycle returns to IDLE.
               if (!bus.resp_valid) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_data  <= lane_data(rd_line, miss_off);
                  bus.resp_mask  <= lane_mask(miss_off);
               end else begin
                  flush_pending <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (bus.flush)
            valid <= '0;
         else if (last_fill && !flush_pending)
            valid[miss_idx] <= 1'b1;

         if (bus.flush && (state == MISS_REQ || state == MISS_WAIT))
            flush_pending <= 1'b1;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (accept) begin
         if (hit)
            hit_count  <= hit_count + 32'd1;
         else
            miss_count <= miss_count + 32'd1;
      end
   end
`endif
endmodule
